// File: rtl/multdiv_pkg.sv
// Shared types for the iterative multiply/divide unit.
// FSM states and the default datapath width.
package multdiv_pkg;

   localparam int DEF_WIDTH = 32;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MUL,
      ST_DIV,
      ST_DONE
   } state_t;

endpackage

// File: rtl/multdiv_addsub.sv
// N-bit adder/subtractor shared by the Booth and restoring steps.
// Ports: a, b operands; sub selects a-b; sum result (carry-out dropped).
module multdiv_addsub #(
   parameter int N = 33
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         sub,
   output logic [N-1:0] sum
);

   logic [N-1:0] cin;

   assign cin = {{(N-1){1'b0}}, sub};
   assign sum = a + (b ^ {N{sub}}) + cin;

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiply (radix-2 Booth) and divide (restoring).
// Ports: clock, reset (async low), data_operandA/B, ctrl_MULT/DIV in;
//        data_result, data_exception, data_resultRDY, busy out.
module multdiv_unit
   import multdiv_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH);
   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] lo;
   logic             qm1;
   logic [WIDTH-1:0] opa;
   logic [WIDTH:0]   rem;
   logic             neg;
   logic             dz;
   logic             ovf;

   logic             start;
   logic [WIDTH-1:0] a_abs;
   logic [WIDTH-1:0] b_abs;
   logic [1:0]       booth;
   logic [WIDTH:0]   as_a;
   logic [WIDTH:0]   as_b;
   logic             as_sub;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   p_ext;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   hi;

   assign start = ctrl_MULT | ctrl_DIV;
   assign booth = {lo[0], qm1};
   assign shifted = {rem[WIDTH-1:0], lo[WIDTH-1]};
   assign hi = {acc, lo[WIDTH-1]};

   assign a_abs = data_operandA[WIDTH-1] ?
                  (~data_operandA + ONE) : data_operandA;
   assign b_abs = data_operandB[WIDTH-1] ?
                  (~data_operandB + ONE) : data_operandB;

   always_comb begin
      as_a   = {acc[WIDTH-1], acc};
      as_b   = {opa[WIDTH-1], opa};
      as_sub = (booth == 2'b10);
      if (state == ST_DIV) begin
         as_a   = shifted;
         as_b   = {1'b0, opa};
         as_sub = 1'b1;
      end
   end

   multdiv_addsub #(.N(WIDTH + 1)) u_addsub (
      .a   (as_a),
      .b   (as_b),
      .sub (as_sub),
      .sum (sum)
   );

   // Booth pairs 00/11 leave P alone; shift happens either way.
   assign p_ext = (booth[1] ^ booth[0]) ? sum : {acc[WIDTH-1], acc};

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state          <= ST_IDLE;
         cnt            <= '0;
         acc            <= '0;
         lo             <= '0;
         qm1            <= 1'b0;
         opa            <= '0;
         rem            <= '0;
         neg            <= 1'b0;
         dz             <= 1'b0;
         ovf            <= 1'b0;
         busy           <= 1'b0;
         data_result    <= '0;
         data_exception <= 1'b0;
         data_resultRDY <= 1'b0;
      end else begin
         data_resultRDY <= 1'b0;
         if (start) begin
            cnt  <= '0;
            busy <= 1'b1;
            acc  <= '0;
            rem  <= '0;
            qm1  <= 1'b0;
            if (ctrl_MULT) begin
               state <= ST_MUL;
               opa   <= data_operandA;
               lo    <= data_operandB;
            end else begin
               state <= ST_DIV;
               opa   <= b_abs;
               lo    <= a_abs;
               neg   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
               dz    <= (data_operandB == '0);
               ovf   <= (data_operandA == INT_MIN) &&
                        (&data_operandB);
            end
         end else begin
            unique case (state)
               ST_MUL: begin
                  if (cnt == LAST) begin
                     state          <= ST_DONE;
                     busy           <= 1'b0;
                     data_resultRDY <= 1'b1;
                     data_result    <= lo;
                     data_exception <= !((&hi) || !(|hi));
                  end else begin
                     cnt <= cnt + 1'b1;
                     acc <= p_ext[WIDTH:1];
                     lo  <= {p_ext[0], lo[WIDTH-1:1]};
                     qm1 <= lo[0];
                  end
               end
               ST_DIV: begin
                  if (cnt == LAST) begin
                     state          <= ST_DONE;
                     busy           <= 1'b0;
                     data_resultRDY <= 1'b1;
                     if (dz) begin
                        data_result    <= '0;
                        data_exception <= 1'b1;
                     end else begin
                        data_result    <= neg ? (~lo + ONE) : lo;
                        data_exception <= ovf;
                     end
                  end else begin
                     cnt <= cnt + 1'b1;
                     if (!sum[WIDTH]) begin
                        rem <= sum;
                        lo  <= {lo[WIDTH-2:0], 1'b1};
                     end else begin
                        rem <= shifted;
                        lo  <= {lo[WIDTH-2:0], 1'b0};
                     end
                  end
               end
               ST_DONE: state <= ST_IDLE;
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_multdiv_unit.sv
// Scoreboard bench for multdiv_unit.
// Stimulus queues expected results; a monitor checks each RDY pulse.
module tb_multdiv_unit;

   logic        clock;
   logic        reset;
   logic [31:0] data_operandA;
   logic [31:0] data_operandB;
   logic        ctrl_MULT;
   logic        ctrl_DIV;
   logic [31:0] data_result;
   logic        data_exception;
   logic        data_resultRDY;
   logic        busy;

   typedef struct {
      logic [31:0] res;
      logic        exc;
      time         t0;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;

   multdiv_unit dut (
      .clock          (clock),
      .reset          (reset),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .ctrl_MULT      (ctrl_MULT),
      .ctrl_DIV       (ctrl_DIV),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY),
      .busy           (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string nm,
                        input logic [63:0] act,
                        input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", nm, act, req);
      end
   endtask

   always @(negedge clock) begin
      if (data_resultRDY === 1'b1) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rdy: got 1 want 0 at %0t",
                     $time);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("result", 64'(data_result), 64'(e.res));
            check("exception", 64'(data_exception), 64'(e.exc));
            check("latency", 64'($time - e.t0), 64'(335));
            check("busy_at_rdy", 64'(busy), 64'(0));
         end
      end
   end

   task automatic issue(input logic m, input logic d,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic chk,
                        input logic [31:0] er,
                        input logic ee);
      exp_t e;
      @(negedge clock);
      ctrl_MULT = m;
      ctrl_DIV = d;
      data_operandA = a;
      data_operandB = b;
      @(posedge clock);
      if (chk) begin
         e.res = er;
         e.exc = ee;
         e.t0 = $time;
         q.push_back(e);
      end
      #1;
      ctrl_MULT = 1'b0;
      ctrl_DIV = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 80; i++) begin
         if (q.size() == 0) break;
         @(posedge clock);
      end
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d pending want 0",
                  q.size());
         q.delete();
      end
      @(negedge clock);
   endtask

   initial begin
      reset = 1'b0;
      ctrl_MULT = 1'b0;
      ctrl_DIV = 1'b0;
      data_operandA = '0;
      data_operandB = '0;
      #1;
      check("rst_result", 64'(data_result), 64'(0));
      check("rst_exc", 64'(data_exception), 64'(0));
      check("rst_rdy", 64'(data_resultRDY), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      repeat (2) @(negedge clock);
      reset = 1'b1;

      issue(1, 0, 32'd7, 32'hFFFF_FFFD, 1, 32'hFFFF_FFEB, 0);
      @(negedge clock);
      check("busy_mid", 64'(busy), 64'(1));
      drain();
      @(negedge clock);
      check("rdy_one_cycle", 64'(data_resultRDY), 64'(0));

      issue(1, 0, 32'h0001_0000, 32'h0001_0000, 1, 32'h0, 1);
      drain();
      issue(1, 0, 32'h7FFF_FFFF, 32'd1, 1, 32'h7FFF_FFFF, 0);
      drain();
      issue(1, 0, 32'h8000_0000, 32'h8000_0000, 1, 32'h0, 1);
      drain();

      issue(0, 1, 32'hFFFF_FF9C, 32'd7, 1, 32'hFFFF_FFF2, 0);
      drain();
      issue(0, 1, 32'd100, 32'hFFFF_FFF9, 1, 32'hFFFF_FFF2, 0);
      drain();
      issue(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 1,
            32'h8000_0000, 1);
      drain();

      issue(0, 1, 32'd5, 32'd0, 1, 32'h0, 1);
      repeat (20) @(negedge clock);
      check("held_result", 64'(data_result), 64'h8000_0000);
      check("held_exc", 64'(data_exception), 64'(1));
      check("held_busy", 64'(busy), 64'(1));
      drain();

      issue(1, 0, 32'd3, 32'd4, 0, 32'h0, 0);
      repeat (9) @(negedge clock);
      issue(0, 1, 32'd20, 32'd4, 1, 32'd5, 0);
      drain();
      repeat (5) @(negedge clock);

      issue(1, 1, 32'd6, 32'd7, 1, 32'd42, 0);
      drain();

      issue(1, 0, 32'd9, 32'd9, 0, 32'h0, 0);
      repeat (14) @(negedge clock);
      #2;
      reset = 1'b0;
      #1;
      check("async_result", 64'(data_result), 64'(0));
      check("async_exc", 64'(data_exception), 64'(0));
      check("async_busy", 64'(busy), 64'(0));
      @(posedge clock);
      #2;
      reset = 1'b1;
      repeat (40) @(negedge clock);

      issue(1, 0, 32'd2, 32'd2, 1, 32'd4, 0);
      drain();
      repeat (3) @(negedge clock);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
